// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA datapath: operand width, modular-multiplier
// handshake timing and the modular-exponentiation controller state encoding.
package rsa_pkg;

    localparam int RSA_WIDTH = 256;

    // Number of WAIT cycles in which a (possibly stale) mm_valid is ignored
    localparam int MM_VALID_BLANK = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SCAN,
        ST_MUL_REQ,
        ST_MUL_WAIT,
        ST_SQR_REQ,
        ST_SQR_WAIT,
        ST_DONE
    } mexp_state_e;

endpackage

// File: rtl/mod_exp_ctrl.sv
// Left-to-right binary square-and-multiply controller computing base^exp mod modulus
// by issuing one y*z mod n request at a time to an external modular multiplier.
module mod_exp_ctrl
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH,
    parameter int CW    = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] exp,
    input  logic [WIDTH-1:0] modulus,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] mm_y,
    output logic [WIDTH-1:0] mm_z,
    output logic [WIDTH-1:0] mm_n,
    output logic             mm_start,
    input  logic             mm_valid,
    input  logic [WIDTH-1:0] mm_result
);

    localparam int BW = (MM_VALID_BLANK > 1) ? $clog2(MM_VALID_BLANK + 1) : 1;

    mexp_state_e      state_q, state_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] e_q, e_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    pos_q, pos_d;
    logic [BW-1:0]    blank_q, blank_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] mm_y_q, mm_y_d;
    logic [WIDTH-1:0] mm_z_q, mm_z_d;
    logic [WIDTH-1:0] mm_n_q, mm_n_d;
    logic             mm_start_q, mm_start_d;

    logic [WIDTH-1:0] e_shift;
    logic             e_bit;
    logic             blanked;

    assign e_shift = e_q >> pos_q;
    assign e_bit   = e_shift[0];
    assign blanked = (blank_q < BW'(MM_VALID_BLANK));

    // Outputs are loaded on the transition into a state, so mm_start is high
    // exactly during a REQ state and done exactly during DONE.
    always_comb begin
        state_d    = state_q;
        b_d        = b_q;
        e_d        = e_q;
        n_d        = n_q;
        acc_d      = acc_q;
        pos_d      = pos_q;
        blank_d    = blank_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        result_d   = result_q;
        mm_y_d     = mm_y_q;
        mm_z_d     = mm_z_q;
        mm_n_d     = mm_n_q;
        mm_start_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    b_d     = base;
                    e_d     = exp;
                    n_d     = modulus;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_CHECK;
                end
            end

            ST_CHECK: begin
                if (n_q == '0) begin
                    err_d    = 1'b1;
                    result_d = '0;
                    done_d   = 1'b1;
                    state_d  = ST_DONE;
                end else if (e_q == '0) begin
                    result_d = (n_q == WIDTH'(1)) ? '0 : WIDTH'(1);
                    done_d   = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    pos_d   = CW'(WIDTH - 1);
                    state_d = ST_SCAN;
                end
            end

            ST_SCAN: begin
                if (e_bit) begin
                    acc_d      = WIDTH'(1);
                    mm_y_d     = WIDTH'(1);
                    mm_z_d     = b_q;
                    mm_n_d     = n_q;
                    mm_start_d = 1'b1;
                    state_d    = ST_MUL_REQ;
                end else begin
                    pos_d = pos_q - CW'(1);
                end
            end

            ST_MUL_REQ: begin
                blank_d = '0;
                state_d = ST_MUL_WAIT;
            end

            ST_SQR_REQ: begin
                blank_d = '0;
                state_d = ST_SQR_WAIT;
            end

            ST_MUL_WAIT: begin
                if (blanked) begin
                    blank_d = blank_q + BW'(1);
                end else if (mm_valid) begin
                    acc_d = mm_result;
                    if (pos_q == '0) begin
                        result_d = mm_result;
                        done_d   = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        pos_d      = pos_q - CW'(1);
                        mm_y_d     = mm_result;
                        mm_z_d     = mm_result;
                        mm_n_d     = n_q;
                        mm_start_d = 1'b1;
                        state_d    = ST_SQR_REQ;
                    end
                end
            end

            ST_SQR_WAIT: begin
                if (blanked) begin
                    blank_d = blank_q + BW'(1);
                end else if (mm_valid) begin
                    acc_d = mm_result;
                    if (e_bit) begin
                        mm_y_d     = mm_result;
                        mm_z_d     = b_q;
                        mm_n_d     = n_q;
                        mm_start_d = 1'b1;
                        state_d    = ST_MUL_REQ;
                    end else if (pos_q == '0) begin
                        result_d = mm_result;
                        done_d   = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        pos_d      = pos_q - CW'(1);
                        mm_y_d     = mm_result;
                        mm_z_d     = mm_result;
                        mm_n_d     = n_q;
                        mm_start_d = 1'b1;
                        state_d    = ST_SQR_REQ;
                    end
                end
            end

            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            b_q        <= '0;
            e_q        <= '0;
            n_q        <= '0;
            acc_q      <= '0;
            pos_q      <= '0;
            blank_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            result_q   <= '0;
            mm_y_q     <= '0;
            mm_z_q     <= '0;
            mm_n_q     <= '0;
            mm_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            b_q        <= b_d;
            e_q        <= e_d;
            n_q        <= n_d;
            acc_q      <= acc_d;
            pos_q      <= pos_d;
            blank_q    <= blank_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            result_q   <= result_d;
            mm_y_q     <= mm_y_d;
            mm_z_q     <= mm_z_d;
            mm_n_q     <= mm_n_d;
            mm_start_q <= mm_start_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign result   = result_q;
    assign mm_y     = mm_y_q;
    assign mm_z     = mm_z_q;
    assign mm_n     = mm_n_q;
    assign mm_start = mm_start_q;

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Bench for mod_exp_ctrl: behavioural multiplier responder with variable latency and
// stale-valid emulation, checked against an arithmetic modular-exponentiation model.
module tb_mod_exp_ctrl;

    localparam int W = 256;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] base;
    logic [W-1:0] exp;
    logic [W-1:0] modulus;
    logic         busy;
    logic         done;
    logic         err;
    logic [W-1:0] result;
    logic [W-1:0] mm_y;
    logic [W-1:0] mm_z;
    logic [W-1:0] mm_n;
    logic         mm_start;
    logic         mm_valid;
    logic [W-1:0] mm_result;

    int tests    = 0;
    int failures = 0;
    int req_total  = 0;
    int done_total = 0;

    int unsigned lat_min  = 1;
    int unsigned lat_max  = 6;
    bit          stale_en = 1'b0;
    int unsigned  rsp_cnt;
    logic [W-1:0] rsp_pending;

    mod_exp_ctrl #(.WIDTH(W), .CW(9)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base      (base),
        .exp       (exp),
        .modulus   (modulus),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .result    (result),
        .mm_y      (mm_y),
        .mm_z      (mm_z),
        .mm_n      (mm_n),
        .mm_start  (mm_start),
        .mm_valid  (mm_valid),
        .mm_result (mm_result)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] mulmod(input logic [W-1:0] y, input logic [W-1:0] z,
                                            input logic [W-1:0] n);
        logic [2*W-1:0] p;
        logic [2*W-1:0] r;
        p = {{W{1'b0}}, y} * {{W{1'b0}}, z};
        r = p % {{W{1'b0}}, n};
        return r[W-1:0];
    endfunction

    // Right-to-left exponentiation: deliberately a different algorithm from the DUT
    function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] b, input logic [W-1:0] e,
                                                input logic [W-1:0] n);
        logic [W-1:0] r;
        logic [W-1:0] sq;
        if (n == '0) return '0;
        r  = W'(1) % n;
        sq = b % n;
        for (int i = 0; i < W; i++) begin
            if (e[i]) r = mulmod(r, sq, n);
            sq = mulmod(sq, sq, n);
        end
        return r;
    endfunction

    function automatic int ref_reqs(input logic [W-1:0] e, input logic [W-1:0] n);
        int bitlen;
        if (n == '0 || e == '0) return 0;
        bitlen = 0;
        for (int i = 0; i < W; i++) if (e[i]) bitlen = i + 1;
        return bitlen - 1 + $countones(e);
    endfunction

    function automatic logic [W-1:0] rand_wide();
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W / 32; i++) r = (r << 32) | W'($urandom());
        return r;
    endfunction

    // Responder: optionally keeps the previous valid/result for one cycle after a launch
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mm_valid    <= 1'b0;
            mm_result   <= '0;
            rsp_cnt     <= 0;
            rsp_pending <= '0;
        end else if (mm_start) begin
            rsp_cnt     <= $urandom_range(lat_max, lat_min);
            rsp_pending <= mulmod(mm_y, mm_z, mm_n);
            if (!stale_en) mm_valid <= 1'b0;
        end else if (rsp_cnt > 0) begin
            rsp_cnt <= rsp_cnt - 1;
            if (rsp_cnt == 1) begin
                mm_valid  <= 1'b1;
                mm_result <= rsp_pending;
            end else begin
                mm_valid <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (mm_start) req_total <= req_total + 1;
        if (done) done_total <= done_total + 1;
    end

    task automatic check_output(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        tests++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h required %0h", tag, obs, expv);
        end
    endtask

    task automatic apply_stimulus(input logic [W-1:0] b, input logic [W-1:0] e,
                                  input logic [W-1:0] n, input bit extra_start,
                                  output logic [W-1:0] res, output logic er,
                                  output int reqs, output int dones);
        int r0;
        int d0;
        bit seen;
        r0 = req_total;
        d0 = done_total;
        @(negedge clk);
        base    = b;
        exp     = e;
        modulus = n;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_output("busy_after_start", W'(busy), W'(1));
        seen = 1'b0;
        for (int i = 0; i < 20000 && !seen; i++) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (extra_start && i == 2) begin
                    base    = ~b;
                    exp     = W'(5);
                    modulus = W'(11);
                    start   = 1'b1;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
            end
        end
        start = 1'b0;
        check_output("done_seen", W'(seen), W'(1));
        res = result;
        er  = err;
        @(negedge clk);
        #1;
        reqs  = req_total - r0;
        dones = done_total - d0;
        check_output("busy_after_done", W'(busy), W'(0));
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [W-1:0] res;
        logic [W-1:0] b;
        logic [W-1:0] e;
        logic [W-1:0] n;
        logic         er;
        int           reqs;
        int           dones;
        int           r0;
        bit           got2;

        reset   = 1'b1;
        start   = 1'b0;
        base    = '0;
        exp     = '0;
        modulus = '0;
        repeat (3) @(negedge clk);
        #1;
        check_output("rst_busy", W'(busy), W'(0));
        check_output("rst_done", W'(done), W'(0));
        check_output("rst_err", W'(err), W'(0));
        check_output("rst_result", result, '0);
        check_output("rst_mm_y", mm_y, '0);
        check_output("rst_mm_z", mm_z, '0);
        check_output("rst_mm_n", mm_n, '0);
        check_output("rst_mm_start", W'(mm_start), W'(0));
        @(negedge clk);
        reset = 1'b0;

        // 4^13 mod 497 with a fixed five-cycle responder
        lat_min = 5; lat_max = 5; stale_en = 1'b0;
        apply_stimulus(W'(4), W'(13), W'(497), 1'b0, res, er, reqs, dones);
        check_output("t1_result", res, W'(445));
        check_output("t1_err", W'(er), W'(0));
        check_output("t1_reqs", W'(reqs), W'(6));
        check_output("t1_dones", W'(dones), W'(1));
        repeat (5) @(negedge clk);
        check_output("t1_result_held", result, W'(445));

        // Stale valid from the previous operation must not be consumed
        lat_min = 3; lat_max = 3; stale_en = 1'b1;
        apply_stimulus(W'(2), W'(10), W'(1000), 1'b0, res, er, reqs, dones);
        check_output("t2_result", res, W'(24));
        check_output("t2_reqs", W'(reqs), W'(5));

        lat_min = 1; lat_max = 6;
        apply_stimulus(W'(9), W'(0), W'(7), 1'b0, res, er, reqs, dones);
        check_output("t3_result_m7", res, W'(1));
        check_output("t3_reqs_m7", W'(reqs), W'(0));
        apply_stimulus(W'(9), W'(0), W'(1), 1'b0, res, er, reqs, dones);
        check_output("t3_result_m1", res, W'(0));
        check_output("t3_reqs_m1", W'(reqs), W'(0));

        apply_stimulus(W'(5), W'(3), W'(0), 1'b0, res, er, reqs, dones);
        check_output("t4_err", W'(er), W'(1));
        check_output("t4_result", res, W'(0));
        check_output("t4_reqs", W'(reqs), W'(0));
        apply_stimulus(W'(3), W'(4), W'(10), 1'b0, res, er, reqs, dones);
        check_output("t4_err_cleared", W'(er), W'(0));
        check_output("t4_next_result", res, W'(1));

        // Abort during the first squaring wait
        lat_min = 5; lat_max = 5;
        r0 = req_total;
        @(negedge clk);
        base = W'(4); exp = W'(13); modulus = W'(497); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got2 = 1'b0;
        for (int i = 0; i < 1000 && !got2; i++) begin
            @(negedge clk);
            #1;
            if (req_total - r0 >= 2) got2 = 1'b1;
        end
        check_output("t5_reached_sqr", W'(got2), W'(1));
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_output("t5_busy", W'(busy), W'(0));
        check_output("t5_done", W'(done), W'(0));
        check_output("t5_mm_start", W'(mm_start), W'(0));
        check_output("t5_mm_y", mm_y, '0);
        check_output("t5_mm_z", mm_z, '0);
        check_output("t5_mm_n", mm_n, '0);
        check_output("t5_result", result, '0);
        @(negedge clk);
        reset = 1'b0;
        lat_min = 1; lat_max = 6;
        apply_stimulus(W'(3), W'(5), W'(7), 1'b0, res, er, reqs, dones);
        check_output("t5_new_result", res, W'(5));

        // MSB-only exponent with a second start while busy
        b = rand_wide();
        n = rand_wide() | W'(1);
        e = W'(1) << (W - 1);
        apply_stimulus(b, e, n, 1'b1, res, er, reqs, dones);
        check_output("t6_result", res, ref_modexp(b, e, n));
        check_output("t6_reqs", W'(reqs), W'(256));
        check_output("t6_dones", W'(dones), W'(1));

        for (int k = 0; k < 8; k++) begin
            b = rand_wide();
            n = rand_wide() >> $urandom_range(250, 0);
            if (n == '0) n = W'(3);
            e = (k == 0) ? rand_wide() : (rand_wide() >> $urandom_range(255, 200));
            apply_stimulus(b, e, n, 1'b0, res, er, reqs, dones);
            check_output("rand_result", res, ref_modexp(b, e, n));
            check_output("rand_reqs", W'(reqs), W'(ref_reqs(e, n)));
            check_output("rand_err", W'(er), W'(0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/mod_exp_ctrl.md
Name: mod_exp_ctrl

Overview:
- Computes result = base^exp mod modulus using left-to-right binary square-and-multiply.
- Acts as the initiator on the modular-multiplier request/response interface. It issues one y*z mod n request at a time and consumes each returned product.
- Sits above the multiplier in the RSA datapath. The top level wires its mm_* ports to the mul_mod responder.

Parameters:
- WIDTH, 256, operand/modulus/result width in bits.
- CW, 9, bit-position counter width; must satisfy 2^CW > WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; accepted only in IDLE.
- base  in  WIDTH  base operand, sampled at start.
- exp  in  WIDTH  exponent, sampled at start.
- modulus  in  WIDTH  modulus, sampled at start.
- busy  out  1  high from the cycle after start acceptance until DONE exits.
- done  out  1  one-cycle completion pulse.
- err  out  1  set with done when modulus==0; cleared on next accepted start.
- result  out  WIDTH  final value; held until next accepted start.
- mm_y  out  WIDTH  multiplier operand y.
- mm_z  out  WIDTH  multiplier operand z.
- mm_n  out  WIDTH  multiplier modulus.
- mm_start  out  1  one-cycle multiplier launch pulse.
- mm_valid  in  1  multiplier result valid (level; stays high after completion until next launch).
- mm_result  in  WIDTH  multiplier result, (mm_y*mm_z) mod mm_n.

Behaviour:
- Reset values:
  - busy, done, err, mm_start = 0.
  - result, mm_y, mm_z, mm_n = 0.
  - FSM = IDLE.
- Reset mid-operation aborts immediately. mm_start drops asynchronously; no further requests are issued.
- States: IDLE, CHECK, SCAN, MUL_REQ, MUL_WAIT, SQR_REQ, SQR_WAIT, DONE.
- IDLE:
  - On start=1, latch base/exp/modulus into b_r/e_r/n_r, clear err, go to CHECK.
  - start is ignored in every other state.
- CHECK:
  - n_r==0: err<=1, result<=0, go to DONE.
  - e_r==0: result<=(n_r==1)?0:1, go to DONE.
  - Otherwise go to SCAN with pos<=WIDTH-1.
- SCAN:
  - One bit per cycle; decrement pos until e_r[pos]==1.
  - On hit, acc<=1, go to MUL_REQ. The first set bit is a multiply of 1*base, giving base mod n.
  - SCAN takes at most WIDTH cycles.
- MUL_REQ:
  - Drive mm_y=acc, mm_z=b_r, mm_n=n_r; mm_start=1 for exactly this cycle.
  - Go to MUL_WAIT.
- SQR_REQ:
  - Same as MUL_REQ with mm_y=mm_z=acc.
  - Go to SQR_WAIT.
- *_WAIT:
  - Operands held stable.
  - mm_valid is ignored in the first WAIT cycle, because the responder's valid from the previous operation is stale.
  - From the second WAIT cycle on, mm_valid=1 means acc<=mm_result and advance.
- Advance after MUL:
  - pos==0 → result<=acc, go to DONE.
  - Else pos<=pos-1, go to SQR_REQ.
- Advance after SQR:
  - e_r[pos]==1 → MUL_REQ.
  - Else if pos==0 → result<=acc, DONE.
  - Else pos<=pos-1, SQR_REQ.
- DONE: done=1 for one cycle, busy drops, return to IDLE.
- Operation count: multiplier requests = (bitlen(exp)-1) squarings + popcount(exp) multiplies.
- No timeout: a responder that never asserts mm_valid stalls the FSM until reset.
- base >= modulus is legal, because the first multiply reduces it.
- Width rules:
  - acc is WIDTH bits.
  - pos is CW bits; decrement at 0 never occurs.

Decomposition:
- Shared package rsa_pkg holds:
  - the state enum for mod_exp_ctrl;
  - the RSA_WIDTH=256 constant;
  - the multiplier-interface blanking constant MM_VALID_BLANK=1 (number of WAIT cycles in which mm_valid is ignored).
- No internal sub-module. The multiplier stays external; mod_exp_top instantiates mod_exp_ctrl plus mul_mod.
- The bench uses a behavioural responder with configurable latency and stale-valid emulation.

Test Plan:
- base=4, exp=13, modulus=497, responder latency 5 → result=445, done pulse once, exactly 6 mm_start pulses (3 SQR, 3 MUL), err=0.
- base=2, exp=10, modulus=1000 → result=24, 5 requests; mm_valid held high from the previous operation is not accepted in the first WAIT cycle.
- exp=0, modulus=7 → result=1, zero mm_start pulses; repeat with modulus=1 → result=0.
- modulus=0, base=5, exp=3 → done with err=1, result=0, no requests; next valid start clears err.
- Reset asserted during SQR_WAIT of a 4^13 mod 497 run → all outputs return to 0 immediately; a new start (3^5 mod 7) gives result=5.
- start pulsed again while busy, plus exp=2^255 (MSB only, WIDTH=256) → second start ignored; 1 MUL and 255 SQR requests; result matches the golden model.
